// File: rtl/csr_sequencer_if.sv
// Bundles the request/response handshake and CSR file port of the CSR sequencer.
// The slave modport is the sequencer; the master modport is the requester plus CSR file.
interface csr_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [1:0]  req_sys;
   logic [11:0] req_addr;
   logic [31:0] req_rs1_val;
   logic [4:0]  req_uimm;
   logic        req_rd_zero;
   logic [31:0] req_pc;

   logic [11:0] csr_read_address;
   logic [31:0] csr_read_data;
   logic        csr_readable;
   logic        csr_writeable;
   logic        csr_write_enable;
   logic [11:0] csr_write_address;
   logic [31:0] csr_write_data;
   logic        csr_retired;
   logic        csr_traped;
   logic        csr_mret;
   logic [31:0] csr_ecp;
   logic [3:0]  csr_trap_cause;
   logic        csr_interupt;
   logic        csr_eip;
   logic        csr_sip;
   logic        csr_tip;
   logic [31:0] csr_trap_vector;
   logic [31:0] csr_mret_vector;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rd_data;
   logic        resp_redirect;
   logic [31:0] resp_target;

   modport slave (
      input  req_valid, req_op, req_sys, req_addr, req_rs1_val, req_uimm, req_rd_zero, req_pc,
      output req_ready,
      output csr_read_address,
      input  csr_read_data, csr_readable, csr_writeable,
      output csr_write_enable, csr_write_address, csr_write_data,
      output csr_retired, csr_traped, csr_mret, csr_ecp, csr_trap_cause, csr_interupt,
      input  csr_eip, csr_sip, csr_tip, csr_trap_vector, csr_mret_vector,
      output resp_valid, resp_rd_data, resp_redirect, resp_target,
      input  resp_ready
   );

   modport master (
      output req_valid, req_op, req_sys, req_addr, req_rs1_val, req_uimm, req_rd_zero, req_pc,
      input  req_ready,
      input  csr_read_address,
      output csr_read_data, csr_readable, csr_writeable,
      input  csr_write_enable, csr_write_address, csr_write_data,
      input  csr_retired, csr_traped, csr_mret, csr_ecp, csr_trap_cause, csr_interupt,
      output csr_eip, csr_sip, csr_tip, csr_trap_vector, csr_mret_vector,
      input  resp_valid, resp_rd_data, resp_redirect, resp_target,
      output resp_ready
   );
endinterface

// File: rtl/csr_sequencer.sv
// Executes one SYSTEM-class op at a time: read CSR, decide outcome, commit strobes, respond.
// Pending interrupts sampled at accept take priority over the op itself.
module csr_sequencer (
   input  logic             clk,
   input  logic             reset,
   csr_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StExec, StCommit, StResp} state_e;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  sys_q, sys_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] rs1_q, rs1_d;
   logic [4:0]  uimm_q, uimm_d;
   logic [31:0] pc_q, pc_d;
   logic        eip_q, eip_d, sip_q, sip_d, tip_q, tip_d;
   logic        trap_q, trap_d, intr_q, intr_d, mret_q, mret_d;
   logic        retire_q, retire_d, we_q, we_d, redirect_q, redirect_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] wdata_q, wdata_d, rd_q, rd_d, target_q, target_d;

   logic [31:0] src, new_val, live_target;
   logic        attempt, commit;

   always_comb begin
      src = op_q[2] ? {27'd0, uimm_q} : rs1_q;
      case (op_q[1:0])
         2'b10:   new_val = bus.csr_read_data | src;
         2'b11:   new_val = bus.csr_read_data & ~src;
         default: new_val = src;
      endcase
      // uimm doubles as the rs1 index: set/clear with x0 never writes
      attempt     = (op_q[1:0] == 2'b01) || (uimm_q != 5'd0);
      live_target = !redirect_q ? 32'd0 : (mret_q ? bus.csr_mret_vector : bus.csr_trap_vector);
   end

   always_comb begin
      state_d = state_q;
      op_d = op_q;  sys_d = sys_q;  addr_d = addr_q;  rs1_d = rs1_q;  uimm_d = uimm_q;  pc_d = pc_q;
      eip_d = eip_q;  sip_d = sip_q;  tip_d = tip_q;
      trap_d = trap_q;  intr_d = intr_q;  mret_d = mret_q;  retire_d = retire_q;  we_d = we_q;
      redirect_d = redirect_q;  cause_d = cause_q;  wdata_d = wdata_q;  rd_d = rd_q;
      target_d = target_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               op_d   = bus.req_op;    sys_d  = bus.req_sys;  addr_d = bus.req_addr;
               rs1_d  = bus.req_rs1_val; uimm_d = bus.req_uimm; pc_d  = bus.req_pc;
               eip_d  = bus.csr_eip;   sip_d  = bus.csr_sip;  tip_d  = bus.csr_tip;
               state_d = StExec;
            end
         end
         StExec: begin
            trap_d = 1'b0;  intr_d = 1'b0;  mret_d = 1'b0;  retire_d = 1'b0;  we_d = 1'b0;
            cause_d = 4'd0;  rd_d = 32'd0;  wdata_d = new_val;
            if (eip_q || sip_q || tip_q) begin
               trap_d  = 1'b1;
               intr_d  = 1'b1;
               cause_d = eip_q ? 4'd11 : (sip_q ? 4'd3 : 4'd7);
            end else if (op_q == 3'b000) begin
               unique case (sys_q)
                  2'b00: begin trap_d = 1'b1; cause_d = 4'd11; end
                  2'b01: begin trap_d = 1'b1; cause_d = 4'd3;  end
                  2'b10: begin mret_d = 1'b1; retire_d = 1'b1; end
                  2'b11: begin trap_d = 1'b1; cause_d = 4'd2;  end
                  default: ;
               endcase
            end else if ((op_q[1:0] == 2'b00) || !bus.csr_readable ||
                         (attempt && !bus.csr_writeable)) begin
               trap_d  = 1'b1;
               cause_d = 4'd2;
            end else begin
               retire_d = 1'b1;
               we_d     = attempt;
               rd_d     = bus.csr_read_data;
            end
            redirect_d = trap_d || mret_d;
            state_d    = StCommit;
         end
         StCommit: begin
            target_d = live_target;
            state_d  = bus.resp_ready ? StIdle : StResp;
         end
         StResp: begin
            if (bus.resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         op_q <= '0;  sys_q <= '0;  addr_q <= '0;  rs1_q <= '0;  uimm_q <= '0;  pc_q <= '0;
         eip_q <= 1'b0;  sip_q <= 1'b0;  tip_q <= 1'b0;
         trap_q <= 1'b0;  intr_q <= 1'b0;  mret_q <= 1'b0;  retire_q <= 1'b0;  we_q <= 1'b0;
         redirect_q <= 1'b0;  cause_q <= '0;  wdata_q <= '0;  rd_q <= '0;  target_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;  sys_q <= sys_d;  addr_q <= addr_d;  rs1_q <= rs1_d;  uimm_q <= uimm_d;
         pc_q <= pc_d;
         eip_q <= eip_d;  sip_q <= sip_d;  tip_q <= tip_d;
         trap_q <= trap_d;  intr_q <= intr_d;  mret_q <= mret_d;  retire_q <= retire_d;
         we_q <= we_d;  redirect_q <= redirect_d;  cause_q <= cause_d;  wdata_q <= wdata_d;
         rd_q <= rd_d;  target_q <= target_d;
      end
   end

   always_comb begin
      commit                = (state_q == StCommit);
      bus.req_ready         = (state_q == StIdle);
      bus.csr_read_address  = (state_q == StExec) ? addr_q : 12'd0;
      bus.csr_write_enable  = commit && we_q;
      bus.csr_write_address = (commit && we_q) ? addr_q : 12'd0;
      bus.csr_write_data    = (commit && we_q) ? wdata_q : 32'd0;
      bus.csr_retired       = commit && retire_q;
      bus.csr_traped        = commit && trap_q;
      bus.csr_mret          = commit && mret_q;
      bus.csr_ecp           = (commit && trap_q) ? pc_q : 32'd0;
      bus.csr_trap_cause    = (commit && trap_q) ? cause_q : 4'd0;
      bus.csr_interupt      = commit && trap_q && intr_q;
      bus.resp_valid        = commit || (state_q == StResp);
      bus.resp_rd_data      = bus.resp_valid ? rd_q : 32'd0;
      bus.resp_redirect     = bus.resp_valid && redirect_q;
      // Vector is sampled live in COMMIT and held from target_q afterwards
      bus.resp_target       = commit ? live_target : ((state_q == StResp) ? target_q : 32'd0);
   end

endmodule

// File: tb/tb_csr_sequencer.sv
// Scoreboard bench for csr_sequencer: a CSR-file model computes expected outcomes at issue,
// a monitor checks strobes at commit and the held response until it is accepted.
module tb_csr_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   csr_sequencer_if bus ();
   csr_sequencer u_dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic        trap, intr, mret, ret, we, redirect;
      logic [3:0]  cause;
      logic [11:0] waddr;
      logic [31:0] wdata, ecp, rd, target;
      int          delay;
   } exp_t;

   exp_t exp_q[$];
   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] model_mem [4096];
   logic [31:0] file_mem  [4096];
   bit          file_init = 1'b0;

   function automatic logic is_rd(logic [11:0] a);
      return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'hC00, 12'hF14};
   endfunction
   function automatic logic is_wr(logic [11:0] a);
      return is_rd(a) && (a[11:10] != 2'b11);
   endfunction
   function automatic logic [31:0] init_val(int a);
      case (a)
         12'h340: return 32'h0000_0001;
         12'h300: return 32'h0000_0088;
         12'hC00: return 32'h0000_1234;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
   endfunction

   // CSR file environment: combinational read, write on the DUT strobe
   always_comb begin
      bus.csr_read_data = file_mem[bus.csr_read_address];
      bus.csr_readable  = is_rd(bus.csr_read_address);
      bus.csr_writeable = is_wr(bus.csr_read_address);
   end
   always @(posedge clk) begin
      if (!file_init) begin
         for (int i = 0; i < 4096; i++) file_mem[i] <= init_val(i);
         file_init <= 1'b1;
      end else if (bus.csr_write_enable) begin
         file_mem[bus.csr_write_address] <= bus.csr_write_data;
      end
   end

   function automatic exp_t model(logic [2:0] op, logic [1:0] sys, logic [11:0] addr,
                                  logic [31:0] rs1, logic [4:0] uimm, logic [31:0] pc,
                                  logic [2:0] ints, logic [31:0] tvec, logic [31:0] mvec,
                                  int delay);
      exp_t e;
      logic [31:0] old, src, nv;
      logic att;
      e = '{default: '0};
      e.delay = delay;
      e.ecp   = pc;
      e.waddr = addr;
      if (ints != 3'b000) begin
         e.trap = 1; e.intr = 1;
         e.cause = ints[2] ? 4'd11 : (ints[1] ? 4'd3 : 4'd7);
      end else if (op == 3'b000) begin
         case (sys)
            2'd0: begin e.trap = 1; e.cause = 4'd11; end
            2'd1: begin e.trap = 1; e.cause = 4'd3; end
            2'd2: begin e.mret = 1; e.ret = 1; end
            default: begin e.trap = 1; e.cause = 4'd2; end
         endcase
      end else begin
         old = model_mem[addr];
         src = op[2] ? {27'd0, uimm} : rs1;
         att = (op[1:0] == 2'b01) || (uimm != 0);
         nv  = (op[1:0] == 2'b01) ? src : (op[1:0] == 2'b10) ? (old | src) : (old & ~src);
         if (op[1:0] == 2'b00 || !is_rd(addr) || (att && !is_wr(addr))) begin
            e.trap = 1; e.cause = 4'd2;
         end else begin
            e.ret = 1; e.we = att; e.wdata = nv; e.rd = old;
            if (att) model_mem[addr] = nv;
         end
      end
      e.redirect = e.trap || e.mret;
      e.target   = e.mret ? mvec : tvec;
      return e;
   endfunction

   // Monitor and response acceptor
   exp_t cur;
   bit   active = 1'b0;
   int   held = 0, cnt = 0;
   always @(negedge clk) begin
      if (reset) begin
         chk("reset_strobes", {28'd0, bus.csr_write_enable, bus.csr_retired, bus.csr_traped,
             bus.csr_mret}, 32'd0);
         chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
         active = 0;
         bus.resp_ready = 1'b0;
      end else begin
         if (active && !bus.resp_valid) begin
            chk("resp_hold_cycles", held, cur.delay + 1);
            active = 0;
         end
         if (bus.resp_valid && !active) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               cur = exp_q.pop_front();
               active = 1; held = 0; cnt = cur.delay;
               chk("write_enable", {31'd0, bus.csr_write_enable}, {31'd0, cur.we});
               chk("retired", {31'd0, bus.csr_retired}, {31'd0, cur.ret});
               chk("traped", {31'd0, bus.csr_traped}, {31'd0, cur.trap});
               chk("mret", {31'd0, bus.csr_mret}, {31'd0, cur.mret});
               chk("ret_trap_excl", {31'd0, bus.csr_retired & bus.csr_traped}, 32'd0);
               if (cur.we) begin
                  chk("write_address", {20'd0, bus.csr_write_address}, {20'd0, cur.waddr});
                  chk("write_data", bus.csr_write_data, cur.wdata);
               end
               if (cur.trap) begin
                  chk("trap_cause", {28'd0, bus.csr_trap_cause}, {28'd0, cur.cause});
                  chk("interupt", {31'd0, bus.csr_interupt}, {31'd0, cur.intr});
                  chk("ecp", bus.csr_ecp, cur.ecp);
               end
            end
         end else if (bus.csr_write_enable || bus.csr_retired || bus.csr_traped || bus.csr_mret) begin
            chk("stray_strobe", 32'd1, 32'd0);
         end
         if (bus.resp_valid && active) begin
            held++;
            chk("resp_rd_data", bus.resp_rd_data, cur.rd);
            chk("resp_redirect", {31'd0, bus.resp_redirect}, {31'd0, cur.redirect});
            if (cur.redirect) chk("resp_target", bus.resp_target, cur.target);
            bus.resp_ready = (cnt == 0);
            if (cnt > 0) cnt--;
         end else begin
            bus.resp_ready = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic drive(logic [2:0] op, logic [1:0] sys, logic [11:0] addr, logic [31:0] rs1,
                        logic [4:0] uimm, logic [31:0] pc, logic [2:0] ints);
      bus.req_valid = 1'b1;  bus.req_op = op;  bus.req_sys = sys;  bus.req_addr = addr;
      bus.req_rs1_val = rs1; bus.req_uimm = uimm; bus.req_pc = pc;
      bus.req_rd_zero = 1'($urandom_range(0, 1));
      {bus.csr_eip, bus.csr_sip, bus.csr_tip} = ints;
   endtask

   task automatic issue(logic [2:0] op, logic [1:0] sys, logic [11:0] addr, logic [31:0] rs1,
                        logic [4:0] uimm, logic [31:0] pc, logic [2:0] ints,
                        logic [31:0] tvec, logic [31:0] mvec, int delay);
      wait_ready();
      bus.csr_trap_vector = tvec;
      bus.csr_mret_vector = mvec;
      drive(op, sys, addr, rs1, uimm, pc, ints);
      exp_q.push_back(model(op, sys, addr, rs1, uimm, pc, ints, tvec, mvec, delay));
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      {bus.csr_eip, bus.csr_sip, bus.csr_tip} = 3'b000;
   endtask

   logic [11:0] addr_tab [8];
   logic [2:0]  op_tab [8];

   initial begin
      for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);
      addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hC00, 12'hF14, 12'h7C0, 12'h340};
      op_tab   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};
      bus.req_valid = 1'b0;  bus.req_op = '0;  bus.req_sys = '0;  bus.req_addr = '0;
      bus.req_rs1_val = '0;  bus.req_uimm = '0;  bus.req_rd_zero = 1'b0;  bus.req_pc = '0;
      bus.csr_eip = 1'b0;  bus.csr_sip = 1'b0;  bus.csr_tip = 1'b0;
      bus.csr_trap_vector = 32'h100;  bus.csr_mret_vector = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("reset_rd_data", bus.resp_rd_data, 32'd0);
      reset = 1'b0;

      issue(3'b001, 2'd0, 12'h340, 32'hDEADBEEF, 5'd5, 32'h10, 3'b000, 32'h100, 32'h0, 0);
      issue(3'b111, 2'd0, 12'h300, 32'h0, 5'd0, 32'h14, 3'b000, 32'h100, 32'h0, 1);
      issue(3'b111, 2'd0, 12'h300, 32'h0, 5'd8, 32'h18, 3'b000, 32'h100, 32'h0, 0);
      issue(3'b001, 2'd0, 12'hC00, 32'h5, 5'd1, 32'h1C, 3'b000, 32'h100, 32'h0, 0);
      issue(3'b000, 2'd0, 12'h000, 32'h0, 5'd0, 32'h40, 3'b101, 32'h100, 32'h0, 2);
      issue(3'b000, 2'd2, 12'h000, 32'h0, 5'd0, 32'h44, 3'b000, 32'h100, 32'h2000, 3);

      // Reset while in EXEC: the write must be dropped
      wait_ready();
      drive(3'b001, 2'd0, 12'h340, 32'h0BAD0BAD, 5'd3, 32'h50, 3'b000);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
      issue(3'b010, 2'd0, 12'h340, 32'h0, 5'd0, 32'h54, 3'b000, 32'h100, 32'h0, 0);

      for (int k = 0; k < 150; k++) begin
         logic [2:0] op;
         logic [2:0] ints;
         logic [4:0] uimm;
         op   = op_tab[$urandom_range(0, 7)];
         ints = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         issue(op, 2'($urandom), addr_tab[$urandom_range(0, 7)], $urandom, uimm, $urandom,
               ints, $urandom, $urandom, $urandom_range(0, 3));
      end

      for (int n = 0; n < 200 && (exp_q.size() != 0 || active); n++) @(negedge clk);
      chk("drain_pending", exp_q.size() + (active ? 1 : 0), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
